// File: rtl/handshake_initiator.sv
// Source-side driver for the full-handshake bus: buffers upstream words in a FIFO and
// issues them one at a time as level-valid requests. Optional macro: HS_INIT_TIMEOUT_EN.
module handshake_initiator #(
  parameter int WIDTH      = 1,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [WIDTH-1:0]     hs_data,
  output logic                 hs_val,
  input  logic                 hs_ack,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tx_count,
  output logic                 err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  if (DEPTH_LOG2 < 1 || TIMEOUT < 2) begin : g_param_chk
    $error("handshake_initiator: DEPTH_LOG2 must be >= 1 and TIMEOUT >= 2");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, fill;
  logic                full, empty, push, load, done, expire;
  logic [0:0]          state;

  assign fill   = wr_ptr - rd_ptr;
  assign full   = fill[DEPTH_LOG2];
  assign empty  = (fill == '0);
  // Ready is forced low while rst is asserted, before the pointers have been cleared.
  assign in_rdy = !rst && !full;
  assign push   = in_val && in_rdy;
  assign hs_val = (state == REQ);
  assign busy   = !empty || hs_val;
  assign done   = hs_val && (hs_ack || expire);
  assign load   = (!hs_val || done) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hs_data  <= '0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        hs_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        state   <= REQ;
      end else if (done) begin
        state <= IDLE;
      end
      if (hs_val && hs_ack) tx_count <= tx_count + CNT_WIDTH'(1);
    end
  end

`ifdef HS_INIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  // An ack in the same cycle as the limit wins: the word counts and no error is raised.
  assign expire = hs_val && !hs_ack && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= expire;
      if (load) to_cnt <= '0;
      else if (hs_val && !hs_ack) to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_initiator.sv
// Directed bench for handshake_initiator: queue-based model checked every cycle plus
// hand-computed literal checkpoints.
module tb_handshake_initiator;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TIMEOUT    = 8;
  localparam int CNT_WIDTH  = 4;

  logic                 clk = 1'b0;
  logic                 rst, in_val, in_rdy, hs_val, hs_ack, busy, err;
  logic [WIDTH-1:0]     in_data, hs_data;
  logic [CNT_WIDTH-1:0] tx_count;

  int n_cmp = 0;
  int n_err = 0;

  handshake_initiator #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .hs_data(hs_data), .hs_val(hs_val), .hs_ack(hs_ack), .busy(busy),
    .tx_count(tx_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: words waiting in the FIFO, the word currently requested, and the count.
  logic [WIDTH-1:0]     mq[$];
  logic                 m_active;
  logic [WIDTH-1:0]     m_data;
  int                   m_age;
  logic [CNT_WIDTH-1:0] m_cnt;
  logic                 m_err;
  bit                   m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_data   = '0;
      m_age    = 0;
      m_cnt    = '0;
      m_err    = 1'b0;
      m_ok     = 1'b1;
    end else if (m_ok) begin
      bit acc, fin;
      int qn;
      qn    = mq.size();
      acc   = in_val && (qn < DEPTH);
      fin   = 1'b0;
      m_err = 1'b0;
      if (m_active) begin
        m_age++;
        if (hs_ack) begin
          m_cnt = m_cnt + 1'b1;
          fin   = 1'b1;
        end
`ifdef HS_INIT_TIMEOUT_EN
        else if (m_age == TIMEOUT) begin
          m_err = 1'b1;
          fin   = 1'b1;
        end
`endif
      end
      if ((!m_active || fin) && qn > 0) begin
        m_data   = mq.pop_front();
        m_active = 1'b1;
        m_age    = 0;
      end else if (fin) begin
        m_active = 1'b0;
      end
      if (acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("in_rdy",   in_rdy,   !rst && (mq.size() < DEPTH));
      check("hs_val",   hs_val,   m_active);
      check("hs_data",  hs_data,  m_data);
      check("busy",     busy,     m_active || (mq.size() > 0));
      check("tx_count", tx_count, m_cnt);
      check("err",      err,      m_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench watchdog expired");
  end

  logic [WIDTH-1:0] seq [6];

  initial begin
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst = 1'b1; in_val = 1'b0; in_data = '0; hs_ack = 1'b0;
    repeat (3) tick();
    check("rst_in_rdy", in_rdy, 0);
    check("rst_hs_val", hs_val, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_busy", busy, 0);

    // Single word, ack at edge 6.
    rst = 1'b0; in_val = 1'b1; in_data = 8'hA5;
    tick();
    in_val = 1'b0;
    tick();
    check("t1_hs_val", hs_val, 1);
    check("t1_hs_data", hs_data, 8'hA5);
    repeat (3) tick();
    hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    check("t1_done_hs_val", hs_val, 0);
    check("t1_tx_count", tx_count, 1);
    check("t1_busy", busy, 0);
    tick();

    // Fill: one active word plus four queued, then a blocked sixth word.
    in_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = seq[i];
      tick();
    end
    check("t2_full_in_rdy", in_rdy, 0);
    check("t2_head", hs_data, 8'h11);
    in_data = seq[5];
    tick();
    check("t2_blocked_in_rdy", in_rdy, 0);
    hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    check("t2_pop_in_rdy", in_rdy, 1);
    check("t2_pop_data", hs_data, 8'h22);
    tick();
    in_val = 1'b0;
    check("t2_refill_in_rdy", in_rdy, 0);
    for (int i = 1; i < 6; i++) begin
      tick();
      tick();
      check("t2_seq_data", hs_data, seq[i]);
      check("t2_seq_val", hs_val, 1);
      hs_ack = 1'b1;
      tick();
      hs_ack = 1'b0;
    end
    check("t2_end_hs_val", hs_val, 0);
    check("t2_tx_count", tx_count, 7);

    // Spurious ack in IDLE.
    tick();
    hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    check("t3_tx_count", tx_count, 7);
    check("t3_hs_val", hs_val, 0);
    check("t3_busy", busy, 0);

    // Reset while in REQ with two queued words; ack during reset is dropped.
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h71 + 8'(i);
      tick();
    end
    in_val = 1'b0;
    check("t4_pre_hs_val", hs_val, 1);
    check("t4_pre_data", hs_data, 8'h71);
    rst = 1'b1; hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    check("t4_rst_hs_val", hs_val, 0);
    check("t4_rst_hs_data", hs_data, 0);
    check("t4_rst_tx_count", tx_count, 0);
    check("t4_rst_in_rdy", in_rdy, 0);
    check("t4_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t4_post_hs_val", hs_val, 0);
    check("t4_post_busy", busy, 0);
    check("t4_post_in_rdy", in_rdy, 1);

    // 17 acknowledged words wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      in_val = 1'b1; in_data = 8'(i + 1);
      tick();
      in_val = 1'b0;
      tick();
      tick();
      hs_ack = 1'b1;
      tick();
      hs_ack = 1'b0;
    end
    check("t5_wrap_tx_count", tx_count, 1);
    check("t5_last_data", hs_data, 8'd17);

`ifdef HS_INIT_TIMEOUT_EN
    // No ack: word dropped after its 8th REQ cycle.
    in_val = 1'b1; in_data = 8'hC3;
    tick();
    in_val = 1'b0;
    tick();
    repeat (7) tick();
    check("t6_wait_hs_val", hs_val, 1);
    check("t6_wait_err", err, 0);
    tick();
    check("t6_err", err, 1);
    check("t6_drop_hs_val", hs_val, 0);
    check("t6_drop_busy", busy, 0);
    check("t6_tx_count", tx_count, 1);
    tick();
    check("t6_err_pulse", err, 0);
    // Ack on the 8th cycle wins over the timeout.
    in_val = 1'b1; in_data = 8'h3C;
    tick();
    in_val = 1'b0;
    tick();
    repeat (7) tick();
    hs_ack = 1'b1;
    tick();
    hs_ack = 1'b0;
    check("t7_err", err, 0);
    check("t7_tx_count", tx_count, 2);
    check("t7_hs_val", hs_val, 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
